// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm-clock front end: channel state encoding
// and default hold timing for the button event decoder.
package alarm_pkg;

    typedef enum logic [1:0] {
        ST_DISARMED = 2'd0,
        ST_IDLE     = 2'd1,
        ST_SHORT    = 2'd2,
        ST_LONG     = 2'd3
    } chan_state_e;

    localparam int LONG_TICKS_DEF   = 100;
    localparam int REPEAT_TICKS_DEF = 20;

endpackage

// File: rtl/btn_event_channel.sv
// One button channel: turns a debounced level into press/click/long/repeat/
// release pulses using a four-state FSM and a hold counter.
module btn_event_channel
    import alarm_pkg::*;
#(
    parameter int LONG_TICKS   = LONG_TICKS_DEF,
    parameter int REPEAT_TICKS = REPEAT_TICKS_DEF,
    parameter int CNT_W        = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic press_pulse,
    output logic click_pulse,
    output logic long_pulse,
    output logic repeat_pulse,
    output logic release_pulse,
    output logic held
);

    // Compare against "last count" so the event fires on the edge that
    // would make the counter reach the tick target.
    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_TICKS - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_TICKS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO    = CNT_W'(0);

    chan_state_e      state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             press_r;
    logic             click_r;
    logic             long_r;
    logic             repeat_r;
    logic             release_r;
    logic             held_r;

    // Channel FSM, hold counter and registered event pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_DISARMED;
            cnt_r     <= CNT_ZERO;
            press_r   <= 1'b0;
            click_r   <= 1'b0;
            long_r    <= 1'b0;
            repeat_r  <= 1'b0;
            release_r <= 1'b0;
            held_r    <= 1'b0;
        end else begin
            press_r   <= 1'b0;
            click_r   <= 1'b0;
            long_r    <= 1'b0;
            repeat_r  <= 1'b0;
            release_r <= 1'b0;
            case (state_r)
                ST_DISARMED: begin
                    // A level held through reset must be released before it counts.
                    if (!btn) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_DISARMED;
                    end
                    cnt_r  <= CNT_ZERO;
                    held_r <= 1'b0;
                end
                ST_IDLE: begin
                    if (btn) begin
                        state_r <= ST_SHORT;
                        cnt_r   <= CNT_ONE;
                        press_r <= 1'b1;
                        held_r  <= 1'b1;
                    end else begin
                        cnt_r  <= CNT_ZERO;
                        held_r <= 1'b0;
                    end
                end
                ST_SHORT: begin
                    if (!btn) begin
                        state_r   <= ST_IDLE;
                        cnt_r     <= CNT_ZERO;
                        click_r   <= 1'b1;
                        release_r <= 1'b1;
                        held_r    <= 1'b0;
                    end else if (cnt_r == LONG_LAST) begin
                        state_r <= ST_LONG;
                        cnt_r   <= CNT_ZERO;
                        long_r  <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                ST_LONG: begin
                    // Release wins over a repeat falling due on the same edge.
                    if (!btn) begin
                        state_r   <= ST_IDLE;
                        cnt_r     <= CNT_ZERO;
                        release_r <= 1'b1;
                        held_r    <= 1'b0;
                    end else if (cnt_r == REPEAT_LAST) begin
                        cnt_r    <= CNT_ZERO;
                        repeat_r <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_r <= ST_DISARMED;
                    cnt_r   <= CNT_ZERO;
                    held_r  <= 1'b0;
                end
            endcase
        end
    end

    assign press_pulse   = press_r;
    assign click_pulse   = click_r;
    assign long_pulse    = long_r;
    assign repeat_pulse  = repeat_r;
    assign release_pulse = release_r;
    assign held          = held_r;

endmodule

// File: rtl/button_event_decoder.sv
// Converts N debounced button levels into one-cycle event pulses; one
// independent channel per button, the top level only wires bits.
module button_event_decoder
    import alarm_pkg::*;
#(
    parameter int N_BTN        = 5,
    parameter int LONG_TICKS   = LONG_TICKS_DEF,
    parameter int REPEAT_TICKS = REPEAT_TICKS_DEF,
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_in,
    output logic [N_BTN-1:0] press_pulse,
    output logic [N_BTN-1:0] click_pulse,
    output logic [N_BTN-1:0] long_pulse,
    output logic [N_BTN-1:0] repeat_pulse,
    output logic [N_BTN-1:0] release_pulse,
    output logic [N_BTN-1:0] held
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        btn_event_channel #(
            .LONG_TICKS   (LONG_TICKS),
            .REPEAT_TICKS (REPEAT_TICKS),
            .CNT_W        (CNT_W)
        ) u_chan (
            .clk           (clk),
            .rst_n         (rst_n),
            .btn           (btn_in[i]),
            .press_pulse   (press_pulse[i]),
            .click_pulse   (click_pulse[i]),
            .long_pulse    (long_pulse[i]),
            .repeat_pulse  (repeat_pulse[i]),
            .release_pulse (release_pulse[i]),
            .held          (held[i])
        );
    end

endmodule

// File: doc/button_event_decoder.md
Name: button_event_decoder

Overview:
- Consumes the N debounced, clock-synchronous button levels produced by the debouncer.
- Converts each level into one-cycle event pulses: press, short click, long press, auto-repeat and release.
- Sits between the debouncer and the alarm-clock control FSM, which acts only on these pulses and never on raw levels.
- Channels are independent; one FSM and one hold counter per button.

Parameters:
- N_BTN, 5, number of button channels.
- LONG_TICKS, 100, held cycles before a long press is declared (1 s at the 10 ms tick).
- REPEAT_TICKS, 20, cycles between auto-repeat pulses once long (200 ms).
- CNT_W, 8, hold-counter width; must satisfy 2^CNT_W > max(LONG_TICKS, REPEAT_TICKS).

Ports:
- clk  in  1  system clock (10 ms period in simulation).
- rst_n  in  1  asynchronous active-low reset.
- btn_in  in  N_BTN  debounced button levels, 1 = pressed, synchronous to clk.
- press_pulse  out  N_BTN  one-cycle pulse on each accepted press.
- click_pulse  out  N_BTN  one-cycle pulse on release before LONG_TICKS.
- long_pulse  out  N_BTN  one-cycle pulse when the hold reaches LONG_TICKS.
- repeat_pulse  out  N_BTN  one-cycle pulse every REPEAT_TICKS while long.
- release_pulse  out  N_BTN  one-cycle pulse on any release of an accepted press.
- held  out  N_BTN  level, 1 while the channel is in SHORT or LONG.

Behaviour:
- Reset and clock: one clock, clk. Asynchronous active-low reset rst_n; assertion takes effect immediately and deassertion is synchronous to clk.
- Reset values: all outputs 0, all channels in DISARMED, counters 0.
- Channel states: DISARMED, IDLE, SHORT, LONG. All outputs are registered.
- DISARMED:
  - btn_in=0 -> IDLE.
  - Otherwise stay in DISARMED.
  - Effect: a button held through reset generates no events until it is released and pressed again.
- IDLE:
  - btn_in=1 at edge k -> SHORT, counter=1.
  - press_pulse=1 for the cycle after edge k; latency is 1 cycle.
- SHORT, btn_in=0 -> IDLE:
  - click_pulse and release_pulse both =1 for one cycle.
  - counter cleared.
- SHORT, btn_in=1:
  - counter increments.
  - When counter reaches LONG_TICKS -> LONG, long_pulse=1 for one cycle, counter reloads to 0.
- LONG, btn_in=1:
  - counter increments.
  - When counter reaches REPEAT_TICKS, repeat_pulse=1 for one cycle and counter reloads to 0.
  - First repeat comes REPEAT_TICKS cycles after long_pulse.
- LONG, btn_in=0 -> IDLE:
  - release_pulse=1, no click_pulse.
  - A repeat due in the same cycle is suppressed.
- Release in the exact cycle the counter reaches LONG_TICKS: treated as a release from SHORT. click_pulse + release_pulse, no long_pulse.
- Counter never wraps; it is reloaded before overflow by the CNT_W constraint.
- Simultaneous events across channels are all reported in the same cycle; there is no priority or masking between channels.
- held equals (state==SHORT || state==LONG), registered. It rises with press_pulse and falls with release_pulse.
- Pulse widths:
  - At most one of press, click, long and repeat is asserted per channel per cycle.
  - release_pulse may coincide only with click_pulse.
- Reset mid-hold: all pulses are dropped immediately and the channel goes to DISARMED; there are no release or click pulses for the interrupted press.

Decomposition:
- Shared package (alarm_pkg): state encoding constants ST_DISARMED=2'd0, ST_IDLE=2'd1, ST_SHORT=2'd2, ST_LONG=2'd3; default tick constants LONG_TICKS_DEF=100 and REPEAT_TICKS_DEF=20.
- Sub-module btn_event_channel, instantiated N_BTN times by generate. It holds one FSM, one counter and the registered outputs for a single button. The top level only wires the bits.

Test Plan:
- Reset with btn_in=0, then btn_in[0]=1 for 5 cycles -> press_pulse[0] at cycle 1 and held[0]=1 for cycles 1-5. Release -> click_pulse[0] and release_pulse[0] in the same single cycle; no long_pulse.
- btn_in[2]=1 for 150 cycles -> press_pulse at 1, long_pulse at 100, repeat_pulse at 120 and 140. Release -> release_pulse only, no click_pulse.
- btn_in[1] held high across rst_n deassertion for 30 cycles -> no pulses. Release then press -> press_pulse[1] 1 cycle after the press.
- btn_in[3]=1 for exactly 99 cycles, then 0 -> click_pulse[3], never long_pulse. Repeat with 100 cycles -> long_pulse at 100, release_pulse at 101, no click_pulse.
- All 5 buttons pressed in the same cycle -> press_pulse=5'b11111 for one cycle. Releasing channels 0 and 4 together -> release_pulse=5'b10001.
- rst_n pulsed low at cycle 60 of a hold on btn_in[4] -> all outputs 0 within the reset window, no release_pulse. After the button is released and pressed again, normal events resume.
